// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Brief    : Load/store stage bridging to a req/ack data bus, with writeback.
// Revision : 1.0
// ============================================================================
module mem_access #(
    parameter int TMO_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        memacc_valid,
    input  logic        memacc_type,
    input  logic [2:0]  memacc_size,
    input  logic [31:0] memacc_addr,
    input  logic [31:0] memacc_data_store,
    input  logic        writeback_valid,
    input  logic [31:0] data_rd,
    input  logic [4:0]  index_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_index,
    output logic [31:0] wb_data,
    output logic        access_err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [TMO_W-1:0] c_cnt_one = {{(TMO_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [TMO_W-1:0] r_cnt;
    logic [4:0]       r_rd;
    logic [2:0]       r_size;
    logic [1:0]       r_lo;
    logic             r_type;

    logic             w_illegal;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_ext;
    logic [TMO_W-1:0] w_cnt_nxt;
    logic             w_timeout;

    assign stall     = (r_state == S_BUSY);
    assign w_cnt_nxt = r_cnt + c_cnt_one;
    assign w_timeout = &w_cnt_nxt;

    always_comb begin
        w_illegal = 1'b0;
        case (memacc_size)
            3'b000, 3'b100: w_illegal = 1'b0;
            3'b001, 3'b101: w_illegal = memacc_addr[0];
            3'b010:         w_illegal = (memacc_addr[1:0] != 2'b00);
            default:        w_illegal = 1'b1;
        endcase
        if (memacc_type && memacc_size[2])
            w_illegal = 1'b1;
    end

    // Lane pattern is shared by loads and stores; only stores carry data.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = memacc_data_store;
        case (memacc_size[1:0])
            2'b00: begin
                w_be    = 4'b0001 << memacc_addr[1:0];
                w_wdata = {4{memacc_data_store[7:0]}};
            end
            2'b01: begin
                w_be    = memacc_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{memacc_data_store[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = memacc_data_store;
            end
        endcase
        if (!memacc_type)
            w_wdata = 32'h0;
    end

    always_comb begin
        w_byte = dmem_rdata[{r_lo, 3'b000} +: 8];
        w_half = dmem_rdata[{r_lo[1], 4'b0000} +: 16];
        case (r_size)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'h0, w_byte};
            3'b101:  w_ext = {16'h0, w_half};
            default: w_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rd       <= 5'd0;
            r_size     <= 3'd0;
            r_lo       <= 2'd0;
            r_type     <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_be    <= 4'h0;
            dmem_wdata <= 32'h0;
            wb_valid   <= 1'b0;
            wb_index   <= 5'd0;
            wb_data    <= 32'h0;
            access_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    wb_valid   <= 1'b0;
                    access_err <= 1'b0;
                    if (enable) begin
                        if (!memacc_valid) begin
                            wb_valid <= writeback_valid;
                            wb_data  <= data_rd;
                            wb_index <= index_rd;
                        end else if (w_illegal) begin
                            access_err <= 1'b1;
                        end else begin
                            r_rd       <= index_rd;
                            r_size     <= memacc_size;
                            r_lo       <= memacc_addr[1:0];
                            r_type     <= memacc_type;
                            dmem_req   <= 1'b1;
                            dmem_we    <= memacc_type;
                            dmem_addr  <= {memacc_addr[31:2], 2'b00};
                            dmem_be    <= w_be;
                            dmem_wdata <= w_wdata;
                            r_cnt      <= '0;
                            r_state    <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    // Ack takes priority over a coincident timeout.
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        r_state  <= S_IDLE;
                        wb_valid <= !r_type;
                        if (!r_type) begin
                            wb_index <= r_rd;
                            wb_data  <= w_ext;
                        end
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        if (w_timeout) begin
                            dmem_req   <= 1'b0;
                            dmem_we    <= 1'b0;
                            access_err <= 1'b1;
                            wb_valid   <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Brief    : Scoreboard bench for mem_access with directed load/store vectors.
// Revision : 1.0
// ============================================================================
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        memacc_valid = 1'b0;
    logic        memacc_type = 1'b0;
    logic [2:0]  memacc_size = 3'd0;
    logic [31:0] memacc_addr = 32'h0;
    logic [31:0] memacc_data_store = 32'h0;
    logic        writeback_valid = 1'b0;
    logic [31:0] data_rd = 32'h0;
    logic [4:0]  index_rd = 5'd0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_index;
    logic [31:0] wb_data;
    logic        access_err;

    mem_access #(.TMO_W(8)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .memacc_valid(memacc_valid), .memacc_type(memacc_type),
        .memacc_size(memacc_size), .memacc_addr(memacc_addr),
        .memacc_data_store(memacc_data_store),
        .writeback_valid(writeback_valid), .data_rd(data_rd), .index_rd(index_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .wb_valid(wb_valid), .wb_index(wb_index),
        .wb_data(wb_data), .access_err(access_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [4:0]  idx;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every writeback or error pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && (wb_valid || access_err)) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_output: wb_valid=%0b access_err=%0b idx=%0d data=0x%08h, expected none",
                         wb_valid, access_err, wb_index, wb_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("mon_err",   {31'h0, access_err}, {31'h0, e.err});
                check("mon_valid", {31'h0, wb_valid},   {31'h0, !e.err});
                if (!e.err) begin
                    check("mon_index", {27'h0, wb_index}, {27'h0, e.idx});
                    check("mon_data",  wb_data, e.data);
                end
            end
        end
    end

    task automatic present(input logic typ, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [4:0] rd);
        enable            = 1'b1;
        memacc_valid      = 1'b1;
        memacc_type       = typ;
        memacc_size       = size;
        memacc_addr       = addr;
        memacc_data_store = sdata;
        index_rd          = rd;
        @(posedge clk);
        #1;
        enable       = 1'b0;
        memacc_valid = 1'b0;
    endtask

    task automatic do_mem(input string name, input logic typ, input logic [2:0] size,
                          input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd,
                          input int waits, input logic [31:0] rdata,
                          input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wdata, input logic [31:0] e_wb);
        present(typ, size, addr, sdata, rd);
        check({name, "_req"},   {31'h0, dmem_req}, 32'd1);
        check({name, "_we"},    {31'h0, dmem_we},  {31'h0, typ});
        check({name, "_addr"},  dmem_addr, e_addr);
        check({name, "_be"},    {28'h0, dmem_be}, {28'h0, e_be});
        check({name, "_wdata"}, dmem_wdata, e_wdata);
        check({name, "_stall"}, {31'h0, stall}, 32'd1);
        for (int i = 0; i < waits; i++) begin
            @(posedge clk);
            #1;
            check({name, "_wait_stall"}, {31'h0, stall}, 32'd1);
            check({name, "_wait_addr"},  dmem_addr, e_addr);
        end
        if (!typ) q.push_back('{err: 1'b0, idx: rd, data: e_wb});
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        check({name, "_done_req"},   {31'h0, dmem_req}, 32'd0);
        check({name, "_done_stall"}, {31'h0, stall},    32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_bad(input string name, input logic typ, input logic [2:0] size,
                          input logic [31:0] addr);
        q.push_back('{err: 1'b1, idx: 5'd0, data: 32'h0});
        present(typ, size, addr, 32'h0, 5'd3);
        check({name, "_req"},   {31'h0, dmem_req},   32'd0);
        check({name, "_stall"}, {31'h0, stall},      32'd0);
        check({name, "_err"},   {31'h0, access_err}, 32'd1);
        @(posedge clk);
        #1;
        check({name, "_err_pulse"}, {31'h0, access_err}, 32'd0);
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_req",   {31'h0, dmem_req},   32'd0);
        check("rst_stall", {31'h0, stall},      32'd0);
        check("rst_wb",    {31'h0, wb_valid},   32'd0);
        check("rst_err",   {31'h0, access_err}, 32'd0);
        check("rst_be",    {28'h0, dmem_be},    32'd0);
        check("rst_addr",  dmem_addr,           32'd0);
        check("rst_wdata", wb_data,             32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset asserted while a transaction is outstanding.
        present(1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd9);
        check("mid_req_before", {31'h0, dmem_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_req_async",   {31'h0, dmem_req}, 32'd0);
        check("mid_stall_async", {31'h0, stall},    32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_wb_after", {31'h0, wb_valid}, 32'd0);

        // Non-memory pass-through.
        q.push_back('{err: 1'b0, idx: 5'd5, data: 32'h1234_5678});
        enable = 1'b1; writeback_valid = 1'b1; data_rd = 32'h1234_5678; index_rd = 5'd5;
        @(posedge clk);
        #1;
        enable = 1'b0; writeback_valid = 1'b0;
        check("pass_req", {31'h0, dmem_req}, 32'd0);
        @(posedge clk);
        #1;

        do_mem("lb",  1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 3, 32'h80FF_0000,
               32'h0000_0100, 4'b1000, 32'h0, 32'hFFFF_FF80);
        do_mem("lbu", 1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd8, 3, 32'h80FF_0000,
               32'h0000_0100, 4'b1000, 32'h0, 32'h0000_0080);
        do_mem("sh",  1'b1, 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 5'd4, 0, 32'h0,
               32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        do_mem("sb",  1'b1, 3'b000, 32'h0000_0001, 32'h0000_0055, 5'd4, 1, 32'h0,
               32'h0000_0000, 4'b0010, 32'h5555_5555, 32'h0);
        do_mem("lh",  1'b0, 3'b001, 32'h0000_0102, 32'h0, 5'd10, 0, 32'h8001_7FFF,
               32'h0000_0100, 4'b1100, 32'h0, 32'hFFFF_8001);
        do_mem("lhu_x0", 1'b0, 3'b101, 32'h0000_0100, 32'h0, 5'd0, 2, 32'h1234_F00D,
               32'h0000_0100, 4'b0011, 32'h0, 32'h0000_F00D);

        do_bad("lw_misal", 1'b0, 3'b010, 32'h0000_0101);
        do_bad("size011",  1'b0, 3'b011, 32'h0000_0100);
        do_bad("sbu",      1'b1, 3'b100, 32'h0000_0100);
        do_bad("lh_odd",   1'b0, 3'b001, 32'h0000_0103);

        // Ack never arrives: request must hold 255 cycles and then abort.
        q.push_back('{err: 1'b1, idx: 5'd0, data: 32'h0});
        present(1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd12);
        for (int i = 1; i < 255; i++) begin
            @(posedge clk);
            #1;
            if (dmem_req !== 1'b1 || dmem_addr !== 32'h0000_0300 || stall !== 1'b1)
                check("tmo_hold", {30'h0, dmem_req, stall}, 32'd3);
        end
        check("tmo_hold_end", {31'h0, dmem_req}, 32'd1);
        @(posedge clk);
        #1;
        check("tmo_req",   {31'h0, dmem_req},   32'd0);
        check("tmo_stall", {31'h0, stall},      32'd0);
        check("tmo_err",   {31'h0, access_err}, 32'd1);
        check("tmo_wb",    {31'h0, wb_valid},   32'd0);
        @(posedge clk);
        #1;

        do_mem("lw_after", 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd12, 0, 32'hDEAD_BEEF,
               32'h0000_0300, 4'b1111, 32'h0, 32'hDEAD_BEEF);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage; the consumer of the execute stage's memacc_*/writeback_* outputs.
- Turns a load/store request into a data-memory bus transaction using a req/ack handshake.
- Sign- or zero-extends load data and presents one writeback record per instruction to the register-file write port.
- Non-memory results pass through with one cycle of latency. The pipeline stalls while a bus transaction is outstanding.

Parameters:
- TMO_W, 8: width of the ack-timeout counter. A transaction aborts when the counter reaches 2^TMO_W-1 cycles without ack.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- enable  in  1  stage enable; inputs are sampled only when high and state is IDLE
- memacc_valid  in  1  instruction is a load/store
- memacc_type  in  1  0 = load, 1 = store
- memacc_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- memacc_addr  in  32  byte address
- memacc_data_store  in  32  store data, right-aligned
- writeback_valid  in  1  non-memory result is valid
- data_rd  in  32  non-memory result
- index_rd  in  5  destination register
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, {addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned write data
- dmem_ack  in  1  bus completion; sampled only while dmem_req is high
- dmem_rdata  in  32  read word, valid with ack
- stall  out  1  upstream must hold its outputs
- wb_valid  out  1  register write this cycle
- wb_index  out  5  destination register
- wb_data  out  32  write data
- access_err  out  1  one-cycle pulse: misaligned access, illegal size, or timeout

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; dmem_req, dmem_we, stall, wb_valid, access_err = 0; dmem_be=0; dmem_addr, dmem_wdata, wb_index, wb_data, counter = 0.
- Reset takes effect mid-transaction: dmem_req drops immediately and the outstanding access is abandoned.
- FSM states: IDLE, BUSY.
- stall = (state==BUSY), decoded from the state register.
- IDLE, enable=0: wb_valid<=0, access_err<=0; nothing is accepted.
- IDLE, enable=1, memacc_valid=0: wb_valid<=writeback_valid, wb_data<=data_rd, wb_index<=index_rd. Latency is 1 cycle.
- IDLE, enable=1, memacc_valid=1, legal and aligned request:
  - latch index_rd, size, addr[1:0], type;
  - drive dmem_req<=1, dmem_we<=type, dmem_addr, dmem_be, dmem_wdata;
  - clear the counter; wb_valid<=0; go to BUSY.
- Illegal or misaligned request: no bus request; access_err<=1 for one cycle; wb_valid<=0; stay in IDLE. Conditions:
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=0;
  - size 011, 110 or 111;
  - store with size[2]=1.
- Store lane mapping:
  - B: be=4'b0001<<addr[1:0], wdata={4{data[7:0]}};
  - H: be=addr[1]?1100:0011, wdata={2{data[15:0]}};
  - W: be=1111, wdata=data.
- Loads drive be with the same lane pattern and wdata=0.
- BUSY, dmem_ack=0: all bus outputs held stable; counter+1. When the counter reaches all-ones: dmem_req<=0, access_err<=1, wb_valid<=0, go to IDLE.
- BUSY, dmem_ack=1: dmem_req<=0, dmem_we<=0, go to IDLE.
  - Load: wb_valid<=1, wb_index<=latched rd, wb_data<=extended data.
  - Store: wb_valid<=0.
- Load extraction:
  - byte = rdata[8*addr[1:0]+:8]; half = rdata[16*addr[1]+:16];
  - B/H sign-extend; BU/HU zero-extend; W uses the word unchanged.
- Load to rd=0: wb_valid still asserts. The register file discards writes to x0.
- Ack and timeout on the same edge: ack wins.
- In BUSY, enable and all upstream inputs are ignored. The transaction always completes or times out.
- Minimum load latency: accept at edge E0, dmem_req high after E0, ack sampled at E1, wb_valid high after E1. stall is high exactly between E0 and E1.
- wb_valid and access_err are single-cycle pulses unless re-triggered.

Test Plan:
- Reset mid-BUSY (req high, no ack), rst low -> dmem_req=0, stall=0 immediately; wb_valid=0 after release.
- Pass-through: enable=1, memacc_valid=0, writeback_valid=1, data_rd=0x1234_5678, index_rd=5 -> next cycle wb_valid=1, wb_index=5, wb_data=0x1234_5678, dmem_req=0.
- LB at addr 0x103, ack after 3 wait cycles with rdata=0x80FF_0000 -> dmem_addr=0x100, be=1000, stall high 4 cycles, wb_data=0xFFFF_FF80. Repeat as LBU -> wb_data=0x0000_0080.
- SH at addr 0x202, data=0xAAAA_BEEF, immediate ack -> dmem_we=1, be=1100, wdata=0xBEEF_BEEF, wb_valid stays 0, stall high 1 cycle.
- LW at addr 0x101 -> no dmem_req, access_err pulses 1 cycle, wb_valid=0. memacc_size=011 -> same response.
- Load with dmem_ack held low -> dmem_req and dmem_addr stable for 255 cycles, then dmem_req=0, access_err=1, wb_valid=0, state IDLE. Next request is accepted normally.
